fp_normalize_round: RTL and testbench

//  Back end of the single-precision FP adder: takes the unnormalized sum from the align/add front end
//  (sign, larger exponent, 25-bit sum mantissa, guard/round/sticky) and renormalizes it.

---
 rtl/fp_normalize_round_if.sv | 29 ++
 rtl/fp_normalize_round.sv | 163 ++++++++++++++++
 tb/tb_fp_normalize_round.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fp_normalize_round_if.sv
// Handshake and data bundle between the FP adder front end, the normalize/round stage
// and the downstream consumer of packed single-precision results.
interface fp_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [24:0] in_mantissa;
  logic        in_guard;
  logic        in_round;
  logic        in_sticky;
  logic [2:0]  rounding_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [2:0]  exception;

  modport master (
    output in_valid, in_sign, in_exponent, in_mantissa, in_guard, in_round, in_sticky,
    output rounding_mode, out_ready,
    input  in_ready, out_valid, out, exception
  );

  modport slave (
    input  in_valid, in_sign, in_exponent, in_mantissa, in_guard, in_round, in_sticky,
    input  rounding_mode, out_ready,
    output in_ready, out_valid, out, exception
  );
endinterface

// File: rtl/fp_normalize_round.sv
// FP adder back end: iterative one-bit-per-cycle renormalization, IEEE-754 rounding
// and packing to single precision with overflow/underflow/inexact flags.
module fp_normalize_round #(
  parameter int EXP_W = 10
) (
  input logic               clk,
  input logic               rst,
  fp_normalize_round_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                    state_r;
  logic                      sign_r;
  logic signed [EXP_W-1:0]   exp_r;
  logic [24:0]               mant_r;
  logic                      g_r;
  logic                      r_r;
  logic                      s_r;
  logic [2:0]                mode_r;
  logic [31:0]               out_r;
  logic [2:0]                exc_r;
  logic                      out_valid_r;
  logic                      in_ready_r;

  logic                      grs_s;
  logic                      inc_s;
  logic [24:0]               sum_s;
  logic [23:0]               m_s;
  logic signed [EXP_W-1:0]   e_s;
  logic [7:0]                ef_s;
  logic [30:0]               mag_s;
  logic [31:0]               out_s;
  logic [2:0]                exc_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.exception = exc_r;

  // Rounding, exponent fix-up and packing of the normalized value held in the datapath.
  always_comb begin
    grs_s = g_r | r_r | s_r;
    inc_s = 1'b0;
    mag_s = 31'h7F800000;
    case (mode_r)
      3'b001:  inc_s = 1'b0;
      3'b010:  inc_s = sign_r & grs_s;
      3'b011:  inc_s = ~sign_r & grs_s;
      3'b100:  inc_s = g_r;
      default: inc_s = g_r & (r_r | s_r | mant_r[0]);
    endcase
    sum_s = {1'b0, mant_r[23:0]} + {24'd0, inc_s};
    if (sum_s[24]) begin
      m_s = sum_s[24:1];
      e_s = exp_r + EXP_W'(1);
    end else begin
      m_s = sum_s[23:0];
      e_s = exp_r;
    end
    // A subnormal that rounded up into the hidden bit keeps exponent field 1.
    if ((e_s == EXP_W'(1)) && !m_s[23]) begin
      ef_s = 8'd0;
    end else begin
      ef_s = e_s[7:0];
    end
    case (mode_r)
      3'b001:  mag_s = 31'h7F7FFFFF;
      3'b010:  mag_s = sign_r ? 31'h7F800000 : 31'h7F7FFFFF;
      3'b011:  mag_s = sign_r ? 31'h7F7FFFFF : 31'h7F800000;
      default: mag_s = 31'h7F800000;
    endcase
    if ((mant_r == 25'd0) && !grs_s) begin
      out_s = {sign_r, 31'd0};
      exc_s = 3'b000;
    end else if (e_s >= EXP_W'(255)) begin
      out_s = {sign_r, mag_s};
      exc_s = 3'b101;
    end else begin
      out_s = {sign_r, ef_s, m_s[22:0]};
      exc_s = {1'b0, grs_s & (ef_s == 8'd0), grs_s};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sign_r      <= 1'b0;
      exp_r       <= '0;
      mant_r      <= 25'd0;
      g_r         <= 1'b0;
      r_r         <= 1'b0;
      s_r         <= 1'b0;
      mode_r      <= 3'b000;
      out_r       <= 32'd0;
      exc_r       <= 3'b000;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            sign_r     <= bus.in_sign;
            exp_r      <= (bus.in_exponent == 8'd0) ? EXP_W'(1) : EXP_W'(bus.in_exponent);
            mant_r     <= bus.in_mantissa;
            g_r        <= bus.in_guard;
            r_r        <= bus.in_round;
            s_r        <= bus.in_sticky;
            mode_r     <= bus.rounding_mode;
            in_ready_r <= 1'b0;
            state_r    <= NORM;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        NORM: begin
          if ((mant_r == 25'd0) && !(g_r | r_r | s_r)) begin
            state_r <= ROUND;
          end else if (mant_r[24]) begin
            // The carry shift costs its own cycle; the next NORM cycle sees bit 23 set.
            mant_r <= {1'b0, mant_r[24:1]};
            g_r    <= mant_r[0];
            r_r    <= g_r;
            s_r    <= s_r | r_r;
            exp_r  <= exp_r + EXP_W'(1);
          end else if (!mant_r[23] && (exp_r > EXP_W'(1))) begin
            mant_r <= {mant_r[23:0], g_r};
            g_r    <= r_r;
            r_r    <= 1'b0;
            exp_r  <= exp_r - EXP_W'(1);
          end else begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          out_r       <= out_s;
          exc_r       <= exc_s;
          out_valid_r <= 1'b1;
          state_r     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: table of operands with hand-computed
// results and latencies, plus stall and mid-operation reset sequences.
module tb_fp_normalize_round;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_normalize_round_if bus ();

  fp_normalize_round #(.EXP_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic        g;
    logic        r;
    logic        s;
    logic [2:0]  mode;
    logic [31:0] exp_out;
    logic [2:0]  exp_exc;
    int          exp_lat;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_sign       = v.sign;
    bus.in_exponent   = v.exp;
    bus.in_mantissa   = v.mant;
    bus.in_guard      = v.g;
    bus.in_round      = v.r;
    bus.in_sticky     = v.s;
    bus.rounding_mode = v.mode;
    bus.in_valid      = 1'b1;
  endtask

  task automatic scramble();
    bus.in_valid      = 1'b0;
    bus.in_sign       = 1'b1;
    bus.in_exponent   = 8'd200;
    bus.in_mantissa   = 25'h1555555;
    bus.in_guard      = 1'b1;
    bus.in_round      = 1'b1;
    bus.in_sticky     = 1'b1;
    bus.rounding_mode = 3'b011;
  endtask

  // Wait (bounded) for in_ready, accept v, measure latency, check result, complete handshake.
  task automatic run_op(input vec_t v, input logic release_out);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check($sformatf("%s_in_ready_timeout", v.name), {31'd0, bus.in_ready}, 32'd1);
      return;
    end
    drive(v);
    @(posedge clk);
    #1;
    scramble();
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("%s_latency", v.name), lat, v.exp_lat);
    check($sformatf("%s_out", v.name), bus.out, v.exp_out);
    check($sformatf("%s_exc", v.name), {29'd0, bus.exception}, {29'd0, v.exp_exc});
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check($sformatf("%s_out_valid_drop", v.name), {31'd0, bus.out_valid}, 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //          name        sgn  exp     mant          G     R     S     mode    out           exc     lat
    vecs[0]  = '{"one_plus_one", 1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h40000000, 3'b000, 3};
    vecs[1]  = '{"cancel",       1'b0, 8'd127, 25'h0000001, 1'b0, 1'b0, 1'b0, 3'b000, 32'h34000000, 3'b000, 25};
    vecs[2]  = '{"tie_rne",      1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0, 3'b000, 32'h3F800002, 3'b001, 2};
    vecs[3]  = '{"tie_rtz",      1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0, 3'b001, 32'h3F800001, 3'b001, 2};
    vecs[4]  = '{"tie_rmm",      1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0, 3'b100, 32'h3F800002, 3'b001, 2};
    vecs[5]  = '{"tie_neg_rdn",  1'b1, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0, 3'b010, 32'hBF800002, 3'b001, 2};
    vecs[6]  = '{"ovf_rne",      1'b0, 8'd254, 25'h1FFFFFE, 1'b0, 1'b0, 1'b0, 3'b000, 32'h7F800000, 3'b101, 3};
    vecs[7]  = '{"ovf_rtz",      1'b0, 8'd254, 25'h1FFFFFE, 1'b0, 1'b0, 1'b0, 3'b001, 32'h7F7FFFFF, 3'b101, 3};
    vecs[8]  = '{"ovf_neg_rup",  1'b1, 8'd254, 25'h1FFFFFE, 1'b0, 1'b0, 1'b0, 3'b011, 32'hFF7FFFFF, 3'b101, 3};
    vecs[9]  = '{"subn_g",       1'b0, 8'd1,   25'h0400000, 1'b1, 1'b0, 1'b0, 3'b000, 32'h00400000, 3'b011, 2};
    vecs[10] = '{"subn_gs",      1'b0, 8'd1,   25'h0400000, 1'b1, 1'b0, 1'b1, 3'b000, 32'h00400001, 3'b011, 2};
    vecs[11] = '{"exact_zero",   1'b1, 8'd50,  25'h0000000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h80000000, 3'b000, 2};
    vecs[12] = '{"mode7_rne",    1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0, 3'b111, 32'h3F800002, 3'b001, 2};
    vecs[13] = '{"exp0_as_1",    1'b0, 8'd0,   25'h0400000, 1'b1, 1'b0, 1'b0, 3'b000, 32'h00400000, 3'b011, 2};
    vecs[14] = '{"max_latency",  1'b0, 8'd127, 25'h0000000, 1'b1, 1'b0, 1'b0, 3'b000, 32'h33800000, 3'b000, 26};
    vecs[15] = '{"round_carry",  1'b0, 8'd127, 25'h0FFFFFF, 1'b1, 1'b1, 1'b0, 3'b000, 32'h40000000, 3'b001, 2};
    vecs[16] = '{"subn_to_norm", 1'b0, 8'd1,   25'h07FFFFF, 1'b1, 1'b1, 1'b0, 3'b000, 32'h00800000, 3'b001, 2};

    bus.out_ready = 1'b0;
    scramble();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_out", bus.out, 32'd0);
    check("reset_exc", {29'd0, bus.exception}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i], 1'b1);
    end

    // Downstream stall: result and flags must hold, no new accept.
    run_op(vecs[2], 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_out", c), bus.out, 32'h3F800002);
      check($sformatf("stall%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("stall%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("stall_release_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("stall_release_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset in the middle of a long normalization discards the operation.
    @(negedge clk);
    drive(vecs[1]);
    @(posedge clk);
    #1;
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_out", bus.out, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        check("midrst_stale_result", {31'd0, bus.out_valid}, 32'd0);
        break;
      end
    end
    run_op(vecs[0], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
